// File: rtl/pixel_fifo_pkg.sv
// Shared FSM state type and colour constants for the pixel stream FIFO.
package pixel_fifo_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } fifo_state_e;

  localparam int DEFAULT_DATA_W = 24;

  localparam logic [23:0] COLOR_BLACK   = 24'h000000;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;

endpackage

// File: rtl/pixel_fifo_mem.sv
// Simple dual-port pixel storage: synchronous write, asynchronous head read.
// The asynchronous read lets the FSM inspect the head sof bit in the same cycle.
module pixel_fifo_mem #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // No reset on storage so it can map onto distributed RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pixel_stream_fifo.sv
// Elastic RGB pixel buffer between producer and LCD timing stage, frame-aligned.
// Optional saturating underflow counter when PIXEL_FIFO_UNDERFLOW_CNT_EN is defined.
module pixel_stream_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int                DATA_W          = DEFAULT_DATA_W,
  parameter int                DEPTH           = 16,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = DATA_W'(COLOR_BLACK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_sof,
  input  logic                     frame_start,
  input  logic                     pix_req,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  fifo_state_e       state_q, state_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              underflow_q, underflow_d;
  logic              first_pix_q, first_pix_d;

  logic              full;
  logic              empty;
  logic              wr_en;
  logic              pop;
  logic              substitute;
  logic              head_sof;
  logic [DATA_W-1:0] head_data;
  logic              head_is_sof;
  logic              serve_first;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign s_ready = !full;
  assign wr_en   = s_valid && !full;
  assign level   = wptr_q - rptr_q;

  pixel_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q[AW-1:0]),
    .wr_data ({s_sof, s_data}),
    .rd_addr (rptr_q[AW-1:0]),
    .rd_data ({head_sof, head_data})
  );

  // Head contents are meaningless while empty, so gate the sof bit.
  assign head_is_sof = !empty && head_sof;
  assign serve_first = frame_start || first_pix_q;

  always_comb begin
    state_d     = state_q;
    pix_data_d  = pix_data_q;
    underflow_d = frame_start ? 1'b0 : underflow_q;
    first_pix_d = frame_start ? 1'b1 : first_pix_q;
    pop         = 1'b0;
    substitute  = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (frame_start && head_is_sof) begin
          state_d = ST_RUN;
        end else if (!empty && !head_sof) begin
          pop = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_start && !head_is_sof) begin
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // The request is served in the state just decided, so a frame_start
    // in the same cycle makes this the first pixel of the new frame.
    if (pix_req) begin
      if ((state_d == ST_RUN) && !empty && !(head_sof && !serve_first)) begin
        pop         = 1'b1;
        pix_data_d  = head_data;
        first_pix_d = 1'b0;
      end else begin
        substitute  = 1'b1;
        pix_data_d  = UNDERFLOW_COLOR;
        underflow_d = 1'b1;
      end
    end

    wptr_d = wptr_q + (AW+1)'(wr_en);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pix_data_q  <= '0;
      underflow_q <= 1'b0;
      first_pix_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pix_data_q  <= pix_data_d;
      underflow_q <= underflow_d;
      first_pix_q <= first_pix_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign underflow = underflow_q;

`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_q, underflow_cnt_d;

  always_comb begin
    underflow_cnt_d = underflow_cnt_q;
    if (substitute && (underflow_cnt_q != 16'hFFFF)) begin
      underflow_cnt_d = underflow_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt_q <= '0;
    end else begin
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed self-checking bench for pixel_stream_fifo (DEPTH 16, black underflow colour).
module tb_pixel_stream_fifo;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        frame_start;
  logic        pix_req;
  logic [23:0] pix_data;
  logic        underflow;
  logic [4:0]  level;
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pixel_stream_fifo #(
    .DATA_W          (24),
    .DEPTH           (16),
    .UNDERFLOW_COLOR (24'h000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .underflow   (underflow),
    .level       (level)
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic sof);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
    frame_start = 1'b0; pix_req = 1'b0;
    tick(); tick();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_pix_data", 32'(pix_data), 32'h0);
    chk("reset_underflow", 32'(underflow), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    tick();
    $display("reset released");

    // Aligned frame of 8 pixels
    push(24'h000001, 1'b1);
    for (int i = 2; i <= 8; i++) push(24'(i), 1'b0);
    chk("preload_level", 32'(level), 32'd8);
    pulse_frame_start();
    pix_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("frame_pix%0d", i), 32'(pix_data), 32'(i));
      $display("pix_req %0d -> pix_data %h", i, pix_data);
    end
    pix_req = 1'b0;
    chk("frame_underflow", 32'(underflow), 32'd0);
    chk("frame_level_end", 32'(level), 32'd0);

    // Empty underflow in RUN, cleared by next frame_start
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("empty_pix_data", 32'(pix_data), 32'h0);
    chk("empty_underflow", 32'(underflow), 32'd1);
    $display("empty req -> pix_data %h underflow %0d", pix_data, underflow);
    pulse_frame_start();
    chk("fs_clears_underflow", 32'(underflow), 32'd0);

    // SYNC drain: three non-sof pixels dropped, sof held
    push(24'h000011, 1'b0);
    chk("drain_level_a", 32'(level), 32'd1);
    push(24'h000012, 1'b0);
    chk("drain_level_b", 32'(level), 32'd1);
    push(24'h000013, 1'b0);
    chk("drain_level_c", 32'(level), 32'd1);
    push(24'hAA0000, 1'b1);
    chk("drain_level_d", 32'(level), 32'd1);
    tick();
    chk("drain_sof_held", 32'(level), 32'd1);
    pulse_frame_start();
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("resync_pix", 32'(pix_data), 32'hAA0000);
    chk("resync_underflow", 32'(underflow), 32'd0);
    $display("resync -> pix_data %h", pix_data);

    // Short frame: A, B, then next frame's sof C must not be consumed
    push(24'h0A0A0A, 1'b1);
    push(24'h0B0B0B, 1'b0);
    push(24'h0C0C0C, 1'b1);
    pulse_frame_start();
    pix_req = 1'b1;
    tick();
    chk("short_pix_a", 32'(pix_data), 32'h0A0A0A);
    tick();
    chk("short_pix_b", 32'(pix_data), 32'h0B0B0B);
    tick();
    pix_req = 1'b0;
    chk("short_pix_sub", 32'(pix_data), 32'h000000);
    chk("short_underflow", 32'(underflow), 32'd1);
    chk("short_c_held", 32'(level), 32'd1);
    // frame_start and pix_req together: C served as first pixel of the new frame
    frame_start = 1'b1;
    pix_req     = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_req     = 1'b0;
    chk("short_pix_c", 32'(pix_data), 32'h0C0C0C);
    chk("short_fs_underflow", 32'(underflow), 32'd0);
    chk("short_level_end", 32'(level), 32'd0);
    $display("short frame -> C delivered %h", pix_data);

    // Full FIFO: simultaneous read and blocked write
    push(24'h000F00, 1'b1);
    for (int i = 1; i <= 15; i++) push(24'h000100 + 24'(i), 1'b0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    pulse_frame_start();
    pix_req = 1'b1;
    s_valid = 1'b1;
    s_data  = 24'hDEAD00;
    s_sof   = 1'b0;
    tick();
    s_valid = 1'b0;
    pix_req = 1'b0;
    chk("full_pop_pix", 32'(pix_data), 32'h000F00);
    chk("full_no_write_level", 32'(level), 32'd15);
    chk("full_s_ready_after", 32'(s_ready), 32'd1);
    $display("full pop -> level %0d s_ready %0d", level, s_ready);
    pix_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    pix_req = 1'b0;
    chk("midframe_last_pix", 32'(pix_data), 32'h00010A);
    chk("midframe_level", 32'(level), 32'd5);

    // Asynchronous reset mid-frame
    #3 rst = 1'b1;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'd0);
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
    chk("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
`endif
    $display("async reset -> level %0d pix_data %h", level, pix_data);
    tick();
    rst = 1'b0;
    tick();
    // Back in SYNC: non-sof pixel is dropped and requests substitute
    push(24'h123456, 1'b0);
    chk("post_rst_level_in", 32'(level), 32'd1);
    tick();
    chk("post_rst_dropped", 32'(level), 32'd0);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("post_rst_sync_sub", 32'(pix_data), 32'h0);
    chk("post_rst_underflow", 32'(underflow), 32'd1);
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
    chk("post_rst_underflow_cnt", 32'(underflow_cnt), 32'd1);
`endif
    $display("SYNC req after reset -> underflow %0d", underflow);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
